// File: rtl/serial_to_parallel_demux.sv
`default_nettype none
// ============================================================================
//  Module   : serial_to_parallel_demux
//  Summary  : Serial-to-parallel receiver. Each qualified bit is steered into
//             its slot of a WIDTH-bit word, and a one-cycle valid pulse is
//             raised for every completed word.
//  Options  : DESER_PARITY_EN - one even-parity bit follows each word and
//             is reported on parity_err.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_to_parallel_demux #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_valid,
    input  logic             serial_data,
    output logic             parallel_valid,
    output logic [WIDTH-1:0] parallel_data,
`ifdef DESER_PARITY_EN
    output logic             parity_err,
`endif
    output logic             busy
);

`ifdef DESER_PARITY_EN
    localparam int c_BITS = WIDTH + 1;
`else
    localparam int c_BITS = WIDTH;
`endif
    localparam int                 c_CNT_W = $clog2(c_BITS);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(c_BITS - 1);

    logic [c_CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0]   asm_q,    asm_d;
    logic [WIDTH-1:0]   pdata_q,  pdata_d;
    logic               pvalid_q, pvalid_d;
    logic [WIDTH-1:0]   w_hit;
    logic [WIDTH-1:0]   w_merged;
    logic               w_last;
`ifdef DESER_PARITY_EN
    logic               perr_q,   perr_d;
`endif

    // Slot decode: each word bit owns one counter value; the parity bit's
    // count (WIDTH) matches no slot and so never disturbs the word.
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_slot
            localparam int c_SLOT = MSB_FIRST ? (WIDTH - 1 - i) : i;
            assign w_hit[i]    = (cnt_q == c_CNT_W'(c_SLOT));
            assign w_merged[i] = (serial_valid && w_hit[i]) ? serial_data : asm_q[i];
        end
    endgenerate

    assign w_last = serial_valid && (cnt_q == c_LAST);

    always_comb begin
        cnt_d    = cnt_q;
        asm_d    = asm_q;
        pdata_d  = pdata_q;
        pvalid_d = 1'b0;
`ifdef DESER_PARITY_EN
        perr_d   = perr_q;
`endif
        if (serial_valid) begin
            if (w_last) begin
                cnt_d    = '0;
                asm_d    = '0;
                pdata_d  = w_merged;
                pvalid_d = 1'b1;
`ifdef DESER_PARITY_EN
                perr_d   = (^asm_q) ^ serial_data;
`endif
            end else begin
                cnt_d = cnt_q + c_CNT_W'(1);
                asm_d = w_merged;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            asm_q    <= '0;
            pdata_q  <= '0;
            pvalid_q <= 1'b0;
`ifdef DESER_PARITY_EN
            perr_q   <= 1'b0;
`endif
        end else begin
            cnt_q    <= cnt_d;
            asm_q    <= asm_d;
            pdata_q  <= pdata_d;
            pvalid_q <= pvalid_d;
`ifdef DESER_PARITY_EN
            perr_q   <= perr_d;
`endif
        end
    end

    assign parallel_valid = pvalid_q;
    assign parallel_data  = pdata_q;
    assign busy           = |cnt_q;
`ifdef DESER_PARITY_EN
    assign parity_err     = perr_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_to_parallel_demux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_to_parallel_demux
//  Summary  : Directed scoreboard bench for serial_to_parallel_demux, one
//             LSB-first and one MSB-first instance driven from the same stream.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_to_parallel_demux;

`ifdef DESER_PARITY_EN
    localparam int c_BITS = 9;
`else
    localparam int c_BITS = 8;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       sv;
    logic       sd;
    logic       lsb_valid, msb_valid, lsb_busy, msb_busy;
    logic [7:0] lsb_data, msb_data;
`ifdef DESER_PARITY_EN
    logic       lsb_perr, msb_perr;
`endif

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [7:0] q_lsb[$];
    logic [7:0] q_msb[$];
    logic [7:0] last_lsb = 8'h00;
    logic [7:0] last_msb = 8'h00;
    logic       q_err[$];
    int         m_cnt;
    logic       m_vld;

    always #5 clk = ~clk;

    serial_to_parallel_demux #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .serial_valid(sv), .serial_data(sd),
        .parallel_valid(lsb_valid), .parallel_data(lsb_data),
`ifdef DESER_PARITY_EN
        .parity_err(lsb_perr),
`endif
        .busy(lsb_busy)
    );

    serial_to_parallel_demux #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .serial_valid(sv), .serial_data(sd),
        .parallel_valid(msb_valid), .parallel_data(msb_data),
`ifdef DESER_PARITY_EN
        .parity_err(msb_perr),
`endif
        .busy(msb_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference bit counter and pulse timing
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt <= 0;
            m_vld <= 1'b0;
        end else begin
            m_vld <= sv && (m_cnt == c_BITS - 1);
            if (sv) m_cnt <= (m_cnt == c_BITS - 1) ? 0 : m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        logic [7:0] e_l, e_m;
        check("lsb_valid", lsb_valid, m_vld);
        check("msb_valid", msb_valid, m_vld);
        check("lsb_busy", lsb_busy, m_cnt != 0);
        check("msb_busy", msb_busy, m_cnt != 0);
        if (rst) begin
            check("lsb_reset_data", lsb_data, 8'h00);
            check("msb_reset_data", msb_data, 8'h00);
            last_lsb = 8'h00;
            last_msb = 8'h00;
        end else if (lsb_valid || msb_valid) begin
            check("pulse_expected", q_lsb.size() > 0, 1'b1);
            if (q_lsb.size() > 0) begin
                e_l = q_lsb.pop_front();
                e_m = q_msb.pop_front();
                check("lsb_word", lsb_data, e_l);
                check("msb_word", msb_data, e_m);
                last_lsb = e_l;
                last_msb = e_m;
`ifdef DESER_PARITY_EN
                begin
                    logic e_p;
                    e_p = q_err.pop_front();
                    check("lsb_parity_err", lsb_perr, e_p);
                    check("msb_parity_err", msb_perr, e_p);
                end
`endif
            end
        end else begin
            check("lsb_hold", lsb_data, last_lsb);
            check("msb_hold", msb_data, last_msb);
        end
    end

    task automatic drive_bit(input logic b);
        @(posedge clk); #2;
        sv = 1'b1;
        sd = b;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #2;
            sv = 1'b0;
            sd = $urandom_range(1);
        end
    endtask

    // Sends w LSB of w first; exp_msb is what the MSB-first instance must show.
    task automatic send_word(input logic [7:0] w, input logic [7:0] exp_msb,
                             input int gap, input logic par_bit, input logic exp_err);
        q_lsb.push_back(w);
        q_msb.push_back(exp_msb);
        q_err.push_back(exp_err);
        for (int i = 0; i < 8; i++) begin
            drive_bit(w[i]);
            if (gap > 0) idle(gap);
        end
`ifdef DESER_PARITY_EN
        drive_bit(par_bit);
`endif
    endtask

    initial begin
        rst = 1'b1;
        sv  = 1'b0;
        sd  = 1'b0;
        // Reset held with toggling inputs
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #2;
            sv = $urandom_range(1);
            sd = $urandom_range(1);
        end
        @(posedge clk); #2;
        rst = 1'b0;
        sv  = 1'b0;
        idle(2);

        // 1,0,1,1,0,0,1,0 -> 4D LSB-first, B2 MSB-first
        send_word(8'h4D, 8'hB2, 0, 1'b0, 1'b0);
        idle(3);
        send_word(8'h4D, 8'hB2, 3, 1'b0, 1'b0);
        idle(3);

        // Back-to-back words, serial_valid held high throughout
        send_word(8'hA5, 8'hA5, 0, 1'b0, 1'b0);
        send_word(8'h3C, 8'h3C, 0, 1'b0, 1'b0);
        send_word(8'hFF, 8'hFF, 0, 1'b0, 1'b0);
        idle(4);

        // Mid-word reset discards the partial word
        for (int i = 0; i < 5; i++) drive_bit(1'b1);
        @(posedge clk); #2;
        rst = 1'b1;
        sv  = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        send_word(8'h81, 8'h81, 0, 1'b0, 1'b0);
        idle(4);

`ifdef DESER_PARITY_EN
        send_word(8'h03, 8'hC0, 0, 1'b0, 1'b0);
        idle(2);
        send_word(8'h07, 8'hE0, 0, 1'b0, 1'b1);
        idle(4);
`endif

        check("lsb_queue_drained", q_lsb.size(), 0);
        check("msb_queue_drained", q_msb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_to_parallel_demux.md
Name: serial_to_parallel_demux

Overview:
Receiving end of the team's serial bit-stream link. Accepts one qualified bit per clock and steers each bit into its slot of a WIDTH-bit word. This is a time-division demultiplexer: a counter drives the bit slot select. When a word is complete, the block presents it with a one-cycle valid pulse. It sits between a serial source or serializer and word-oriented consumer logic.

Parameters:
WIDTH, 8, data bits per word; legal range 2..32.
MSB_FIRST, 0, 0 = first received bit lands in parallel_data[0]; 1 = first received bit lands in parallel_data[WIDTH-1].

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
serial_valid  input  1  serial_data is qualified this cycle.
serial_data  input  1  serial bit.
parallel_valid  output  1  one-cycle pulse: a complete word is on parallel_data.
parallel_data  output  WIDTH  last completed word; held stable until the next word completes.
busy  output  1  high while a partial word is held (bit count != 0).

Behaviour:
- Reset, asynchronous and active-high, clears all state:
  - parallel_valid = 0, parallel_data = 0, busy = 0.
  - Bit counter = 0, assembly register = 0.
- Bit counter width is $clog2(WIDTH), range 0..WIDTH-1.
- Cycle with serial_valid = 0: no state change. parallel_valid = 0 next cycle. Gaps of any length are allowed; there is no timeout.
- Cycle with serial_valid = 1 and count < WIDTH-1:
  - Bit is written into the assembly register at slot count (MSB_FIRST = 0) or slot WIDTH-1-count (MSB_FIRST = 1).
  - count increments.
- Cycle with serial_valid = 1 and count == WIDTH-1 (last bit of the word):
  - Next cycle, parallel_data = assembly register with the current bit merged in.
  - parallel_valid = 1 for exactly that one cycle.
  - count wraps to 0 and the assembly register clears.
- Latency: parallel_valid rises on the clock edge that samples the final bit, so it is visible 1 cycle after the final bit's cycle.
- Back-to-back words: a bit arriving in the same cycle parallel_valid is high is accepted as bit 0 of the next word. Zero dead cycles between words.
- parallel_data changes only on word completion (and reset). It never shows partial words.
- busy = (count != 0), decoded from registered state with no combinational input path.
- Reset asserted mid-word: the partial word is discarded and no parallel_valid is produced. The first valid bit after reset release is bit 0 of a new word.
- No backpressure: the consumer must accept the word in the pulse cycle.

Optional Feature:
Macro DESER_PARITY_EN.
- Defined:
  - Each word is WIDTH data bits followed by one even-parity bit, i.e. WIDTH+1 serial bits; the counter range extends to 0..WIDTH.
  - parallel_valid pulses after the parity bit is sampled, not after the last data bit.
  - Extra output port parity_err (1 bit, reset 0) is registered alongside parallel_valid and updates only on word completion.
  - parity_err = XOR of the WIDTH data bits and the parity bit; 1 means mismatch.
  - The word is delivered on parallel_data even when parity_err = 1.
- Undefined: the parity_err port is absent; behaviour is exactly as above.

Test Plan:
- Reset: hold rst = 1 with toggling inputs → parallel_valid = 0, parallel_data = 0, busy = 0 throughout; after release, busy = 0.
- LSB-first word, WIDTH = 8, MSB_FIRST = 0: send bits 1,0,1,1,0,0,1,0 on consecutive cycles → single-cycle parallel_valid 1 cycle after the 8th bit; parallel_data = 8'h4D.
- MSB-first word, MSB_FIRST = 1: same bit sequence → parallel_data = 8'hB2. With gaps of 3 idle cycles between bits → same result; busy = 1 from the first bit until the pulse.
- Back-to-back: 3 words 8'hA5, 8'h3C, 8'hFF with serial_valid held high for 24 cycles → pulses 8 cycles apart carrying those values in order; parallel_data stable between pulses.
- Mid-word reset: send 5 bits, pulse rst for 1 cycle, then send a full word of 8'h81 → exactly one pulse, with data 8'h81.
- With DESER_PARITY_EN defined:
  - Send 8'h03 followed by parity bit 0 → pulse with parity_err = 0.
  - Send 8'h07 followed by parity bit 0 → pulse with parity_err = 1 and parallel_data = 8'h07.
